// File: rtl/wb_regfile.sv
// Write-back select, 32-entry architectural register file and committed-write counter.
// Optional macro WB_BYPASS_EN: forward the in-flight write-back value to same-cycle reads.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_i,
    input  logic              RegData_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] MemData_i,
    input  logic [ADDR_W-1:0] Rd_i,
    input  logic [ADDR_W-1:0] Rs_i,
    input  logic [ADDR_W-1:0] Rt_i,
    output logic [DATA_W-1:0] RsData_o,
    output logic [DATA_W-1:0] RtData_o,
    output logic [DATA_W-1:0] WBData_o,
    output logic [CNT_W-1:0]  WrCount_o
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    // Index 0 has no storage; it is hardwired to zero on the read side.
    logic [DATA_W-1:0] r_regs [1:NREGS-1];
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] w_wbdata;
    logic              w_commit;
    logic [DATA_W-1:0] w_rs_stored;
    logic [DATA_W-1:0] w_rt_stored;

    assign w_wbdata    = RegData_i ? MemData_i : ALUResult_i;
    assign w_commit    = RegWrite_i && (Rd_i != '0);
    assign w_rs_stored = (Rs_i == '0) ? '0 : r_regs[Rs_i];
    assign w_rt_stored = (Rt_i == '0) ? '0 : r_regs[Rt_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[Rd_i] <= w_wbdata;
            r_count      <= r_count + CNT_W'(1);
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        RsData_o = w_rs_stored;
        RtData_o = w_rt_stored;
        if (rst) begin
            RsData_o = '0;
            RtData_o = '0;
        end else begin
            // w_commit already excludes index 0, so register 0 is never bypassed.
            if (w_commit && (Rs_i == Rd_i)) RsData_o = w_wbdata;
            if (w_commit && (Rt_i == Rd_i)) RtData_o = w_wbdata;
        end
    end
`else
    assign RsData_o = w_rs_stored;
    assign RtData_o = w_rt_stored;
`endif

    assign WBData_o  = w_wbdata;
    assign WrCount_o = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected outputs, a negedge monitor checks them.
module tb_wb_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

    localparam int K_RS  = 0;
    localparam int K_RT  = 1;
    localparam int K_WB  = 2;
    localparam int K_CNT = 3;

    logic              clk;
    logic              rst;
    logic              RegWrite_i;
    logic              RegData_i;
    logic [DATA_W-1:0] ALUResult_i;
    logic [DATA_W-1:0] MemData_i;
    logic [ADDR_W-1:0] Rd_i;
    logic [ADDR_W-1:0] Rs_i;
    logic [ADDR_W-1:0] Rt_i;
    logic [DATA_W-1:0] RsData_o;
    logic [DATA_W-1:0] RtData_o;
    logic [DATA_W-1:0] WBData_o;
    logic [CNT_W-1:0]  WrCount_o;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         item;
    logic [31:0] act;
    int          n_checks = 0;
    int          n_fail   = 0;

    wb_regfile #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWrite_i (RegWrite_i),
        .RegData_i  (RegData_i),
        .ALUResult_i(ALUResult_i),
        .MemData_i  (MemData_i),
        .Rd_i       (Rd_i),
        .Rs_i       (Rs_i),
        .Rt_i       (Rt_i),
        .RsData_o   (RsData_o),
        .RtData_o   (RtData_o),
        .WBData_o   (WBData_o),
        .WrCount_o  (WrCount_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: inputs change just after posedge, so negedge sees settled combinational outputs
    // and the state committed at the preceding edge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            case (item.kind)
                K_RS:    act = RsData_o;
                K_RT:    act = RtData_o;
                K_WB:    act = WBData_o;
                default: act = 32'(WrCount_o);
            endcase
            n_checks++;
            if (act !== item.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", item.name, act, item.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic we, input logic sel, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        RegWrite_i  = we;
        RegData_i   = sel;
        ALUResult_i = alu;
        MemData_i   = mem;
        Rd_i        = rd;
        Rs_i        = rs;
        Rt_i        = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] byp_exp;
    int          drain;

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd5, 5'd0, 5'd0);
        step();
        step();

        // Post-reset: every index reads zero, commit during reset was dropped.
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
            expect_val($sformatf("reset_rs%0d", i), K_RS, 32'h0);
            expect_val($sformatf("reset_rt%0d", 31 - i), K_RT, 32'h0);
            step();
        end
        expect_val("reset_cnt", K_CNT, 32'd0);
        step();

        // Source select: ALU path then memory path.
        drive(1'b1, 1'b0, 32'h1234_5678, 32'hCAFE_0000, 5'd3, 5'd0, 5'd0);
        expect_val("wb_sel_alu", K_WB, 32'h1234_5678);
        step();
        drive(1'b1, 1'b1, 32'h0000_0BAD, 32'hDEAD_BEEF, 5'd4, 5'd0, 5'd0);
        expect_val("wb_sel_mem", K_WB, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);
        expect_val("read_r3", K_RS, 32'h1234_5678);
        expect_val("read_r4", K_RT, 32'hDEAD_BEEF);
        expect_val("cnt_after_2", K_CNT, 32'd2);
        step();

        // Zero register: write discarded, not counted, never bypassed.
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_val("r0_pre_rs", K_RS, 32'h0);
        expect_val("r0_pre_rt", K_RT, 32'h0);
        expect_val("r0_wb", K_WB, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_val("r0_post", K_RS, 32'h0);
        expect_val("r0_cnt", K_CNT, 32'd2);
        step();

        // Same-cycle read of a register being written.
        drive(1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd7, 5'd0, 5'd0);
        step();
`ifdef WB_BYPASS_EN
        byp_exp = 32'h0000_0022;
`else
        byp_exp = 32'h0000_0011;
`endif
        drive(1'b1, 1'b0, 32'h0000_0022, 32'h0, 5'd7, 5'd7, 5'd7);
        expect_val("byp_pre_rs", K_RS, byp_exp);
        expect_val("byp_pre_rt", K_RT, byp_exp);
        expect_val("byp_pre_cnt", K_CNT, 32'd3);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        expect_val("byp_post_rs", K_RS, 32'h0000_0022);
        expect_val("byp_post_rt", K_RT, 32'h0000_0022);
        expect_val("byp_post_cnt", K_CNT, 32'd4);
        step();

        // RegWrite_i low: no commit, WBData_o still follows the select.
        drive(1'b1, 1'b0, 32'h0000_0099, 32'h0, 5'd9, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9, 5'd9, 5'd7);
        expect_val("nowe_wb", K_WB, 32'hAAAA_AAAA);
        expect_val("nowe_pre_rs", K_RS, 32'h0000_0099);
        step();
        expect_val("nowe_post_rs", K_RS, 32'h0000_0099);
        expect_val("nowe_cnt", K_CNT, 32'd5);
        step();

        // Counter wrap with a 4-bit counter: 17 commits from zero leaves 1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd9);
        expect_val("rst2_r7", K_RS, 32'h0);
        expect_val("rst2_r9", K_RT, 32'h0);
        expect_val("rst2_cnt", K_CNT, 32'd0);
        step();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 32'(i + 32'h100), 32'h0, 5'((i % 31) + 1), 5'd0, 5'd0);
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd17, 5'd1);
        expect_val("wrap_cnt", K_CNT, 32'd1);
        expect_val("wrap_r17", K_RS, 32'h0000_0110);
        expect_val("wrap_r1", K_RT, 32'h0000_0100);
        step();

        // Reset mid-stream drops the same-cycle commit and clears the counter.
        drive(1'b1, 1'b0, 32'h0000_0033, 32'h0, 5'd2, 5'd0, 5'd0);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd2, 5'd0, 5'd0);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd17);
        expect_val("midrst_r2", K_RS, 32'h0);
        expect_val("midrst_r17", K_RT, 32'h0);
        expect_val("midrst_cnt", K_CNT, 32'd0);
        step();
        drive(1'b1, 1'b1, 32'h0, 32'h0000_0077, 5'd2, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0);
        expect_val("after_rst_r2", K_RS, 32'h0000_0077);
        expect_val("after_rst_cnt", K_CNT, 32'd1);
        step();

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            step();
            drain++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
